// File: rtl/mmio_interconnect_if.sv
// CPU-side request/response bus of the MMIO interconnect.
interface mmio_interconnect_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                m_valid;
    logic                m_ready;
    logic                m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_be;
    logic                m_rsp_valid;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_err;

    modport master (
        output m_valid, m_we, m_addr, m_wdata, m_be,
        input  m_ready, m_rsp_valid, m_rdata, m_err
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_wdata, m_be,
        output m_ready, m_rsp_valid, m_rdata, m_err
    );
endinterface

// File: rtl/mmio_interconnect.sv
// Address decode, wait-state handshake and error response between the CPU
// data port and NUM_SLAVES memory-mapped targets. One transaction in flight.
module mmio_interconnect #(
    parameter int                         NUM_SLAVES     = 4,
    parameter int                         ADDR_W         = 32,
    parameter int                         DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE   =
        {32'h2000_0000, 32'h0200_4000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK   =
        {32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFF0_0000, 32'hFFF8_0000},
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    mmio_interconnect_if.slave           bus,
    output logic [15:0]                  err_count,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_be,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    hit;
    logic [NUM_SLAVES-1:0]   hit_sel;
    logic [ADDR_W-1:0]       hit_base;
    logic [DATA_W-1:0]       rdata_sel;
    logic                    sel_ready;
    logic                    timeout_hit;
    logic                    err_inc;
    logic [15:0]             err_next;
    logic [31:0]             tmo_count;

    assign bus.m_ready     = (state == IDLE);
    assign bus.m_rsp_valid = (state == RESP);
    assign sel_ready       = |(s_ready & s_sel);
    assign timeout_hit     = (TIMEOUT_CYCLES != 0) &&
                             (tmo_count == 32'(TIMEOUT_CYCLES - 1));

    // Decode the incoming address; walking down from the top lets the lowest matching index win.
    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_base = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit      = 1'b1;
                hit_sel  = NUM_SLAVES'(1) << i;
                hit_base = SLAVE_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Pick the read data of the currently selected slave.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_sel[i]) begin
                rdata_sel = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Error responses come from a decode miss at accept or a timeout without ready.
    always_comb begin
        err_inc  = ((state == IDLE) && bus.m_valid && !hit) ||
                   ((state == ACCESS) && !sel_ready && timeout_hit);
        err_next = (err_inc && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: misses skip straight to the response, hits wait for ready or timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.m_valid) begin
                    state_next = hit ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latching, slave-side outputs, response capture and the error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_sel       <= '0;
            s_we        <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_be        <= '0;
            bus.m_rdata <= '0;
            bus.m_err   <= 1'b0;
            tmo_count   <= '0;
            err_count   <= '0;
        end else begin
            err_count <= err_next;
            case (state)
                IDLE: begin
                    if (bus.m_valid) begin
                        s_we      <= bus.m_we;
                        s_addr    <= bus.m_addr - hit_base;
                        s_wdata   <= bus.m_wdata;
                        s_be      <= bus.m_be;
                        s_sel     <= hit_sel;
                        tmo_count <= '0;
                        if (!hit) begin
                            bus.m_rdata <= '0;
                            bus.m_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    tmo_count <= tmo_count + 32'd1;
                    if (sel_ready) begin
                        bus.m_rdata <= s_we ? '0 : rdata_sel;
                        bus.m_err   <= 1'b0;
                        s_sel       <= '0;
                    end else if (timeout_hit) begin
                        bus.m_rdata <= '0;
                        bus.m_err   <= 1'b1;
                        s_sel       <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed, table-driven bench for mmio_interconnect with TIMEOUT_CYCLES=4.
module tb_mmio_interconnect;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] err_count;
    logic [3:0]  s_sel;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic [3:0]  s_ready = 4'b0;
    logic [127:0] s_rdata = '0;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_err_cnt = 16'd0;

    mmio_interconnect_if bus ();

    mmio_interconnect #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_be      (s_be),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ready_cyc;
        logic [31:0] rdata;
        logic [3:0]  exp_sel;
        logic [31:0] exp_saddr;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bumpErr(input logic e);
        if (e && exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
    endtask

    // One transaction: accept, walk the ACCESS cycles, then check the response and the idle cycle after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        int  cyc;
        bit  got;
        @(posedge clk); #1;
        bus.m_valid = 1'b1;
        bus.m_we    = v.we;
        bus.m_addr  = v.addr;
        bus.m_wdata = v.wdata;
        bus.m_be    = v.be;
        s_ready     = 4'b0;
        for (int i = 0; i < 4; i++) begin
            s_rdata[i*32 +: 32] = v.exp_sel[i] ? v.rdata : (32'hBAD0_0000 | 32'(i));
        end
        @(posedge clk); #1;
        bus.m_valid = 1'b0;
        bus.m_addr  = 32'hFFFF_FFFF;
        bus.m_wdata = 32'h5555_5555;
        bus.m_be    = 4'hF;
        bus.m_we    = ~v.we;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 12) begin
            if (bus.m_rsp_valid) begin
                got = 1'b1;
            end else begin
                checkOutput($sformatf("v%0d c%0d s_sel", idx, cyc), 64'(s_sel), 64'(v.exp_sel));
                checkOutput($sformatf("v%0d c%0d s_addr", idx, cyc), 64'(s_addr), 64'(v.exp_saddr));
                checkOutput($sformatf("v%0d c%0d s_wdata_be_we", idx, cyc),
                            {27'd0, s_we, s_be, s_wdata}, {27'd0, v.we, v.be, v.wdata});
                checkOutput($sformatf("v%0d c%0d m_ready", idx, cyc), 64'(bus.m_ready), 64'd0);
                s_ready = (cyc - 1 == v.ready_cyc) ? v.exp_sel : ~v.exp_sel;
                @(posedge clk); #1;
                cyc++;
            end
        end
        s_ready = 4'b0;
        bumpErr(v.exp_err);
        checkOutput($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.exp_lat));
        checkOutput($sformatf("v%0d m_rdata", idx), 64'(bus.m_rdata), 64'(v.exp_rdata));
        checkOutput($sformatf("v%0d m_err", idx), 64'(bus.m_err), 64'(v.exp_err));
        checkOutput($sformatf("v%0d s_sel_rsp", idx), 64'(s_sel), 64'd0);
        checkOutput($sformatf("v%0d err_count", idx), 64'(err_count), 64'(exp_err_cnt));
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d rsp_pulse", idx), {62'd0, bus.m_rsp_valid, bus.m_ready}, 64'd1);
        checkOutput($sformatf("v%0d rdata_hold", idx), {31'd0, bus.m_err, bus.m_rdata},
                    {31'd0, v.exp_err, v.exp_rdata});
    endtask

    initial begin
        //           we    addr          wdata         be     rdy  rdata         sel     saddr         lat rdata_exp     err
        vecs[0] = '{1'b0, 32'h1000_0010, 32'h0,        4'h0,  0,  32'hCAFE_F00D, 4'b0010, 32'h0000_0010, 2, 32'hCAFE_F00D, 1'b0};
        vecs[1] = '{1'b1, 32'h2000_0004, 32'h41,       4'h1,  3,  32'h1111_2222, 4'b1000, 32'h0000_0004, 5, 32'h0,         1'b0};
        vecs[2] = '{1'b0, 32'h3000_0000, 32'h0,        4'h0,  0,  32'h0,         4'b0000, 32'h0,         1, 32'h0,         1'b1};
        vecs[3] = '{1'b0, 32'h0200_4000, 32'h0,        4'h0,  99, 32'h9999_9999, 4'b0100, 32'h0000_0000, 5, 32'h0,         1'b1};
        vecs[4] = '{1'b0, 32'h0200_4008, 32'h0,        4'h0,  3,  32'h1234_5678, 4'b0100, 32'h0000_0008, 5, 32'h1234_5678, 1'b0};
        vecs[5] = '{1'b0, 32'h0007_FFFC, 32'h0,        4'h0,  1,  32'h5A5A_1234, 4'b0001, 32'h0007_FFFC, 3, 32'h5A5A_1234, 1'b0};
        vecs[6] = '{1'b0, 32'h0200_4010, 32'h0,        4'h0,  0,  32'h0,         4'b0000, 32'h0,         1, 32'h0,         1'b1};
        vecs[7] = '{1'b1, 32'h100F_FFF0, 32'hDEAD_BEEF, 4'hA, 0,  32'h7777_7777, 4'b0010, 32'h000F_FFF0, 2, 32'h0,         1'b0};
        vecs[8] = '{1'b0, 32'h2000_0100, 32'h0,        4'h0,  0,  32'h0,         4'b0000, 32'h0,         1, 32'h0,         1'b1};

        bus.m_valid = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_be    = '0;

        #12;
        checkOutput("reset m_ready_rsp", {62'd0, bus.m_ready, bus.m_rsp_valid}, 64'd2);
        checkOutput("reset s_outputs", {s_sel, s_we, s_be, s_addr}, 64'd0);
        checkOutput("reset s_wdata", 64'(s_wdata), 64'd0);
        checkOutput("reset m_rsp", {31'd0, bus.m_err, bus.m_rdata}, 64'd0);
        checkOutput("reset err_count", 64'(err_count), 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset in the middle of an access drops the select at once and never responds.
        @(posedge clk); #1;
        bus.m_valid = 1'b1;
        bus.m_we    = 1'b0;
        bus.m_addr  = 32'h1000_0000;
        @(posedge clk); #1;
        bus.m_valid = 1'b0;
        checkOutput("midreset s_sel_before", 64'(s_sel), 64'b0010);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset s_sel", 64'(s_sel), 64'd0);
        checkOutput("midreset m_ready", 64'(bus.m_ready), 64'd1);
        checkOutput("midreset err_count", 64'(err_count), 64'd0);
        @(posedge clk); #1;
        checkOutput("midreset no_rsp", 64'(bus.m_rsp_valid), 64'd0);
        rst = 1'b1;
        exp_err_cnt = 16'd0;
        applyStimulus(vecs[0], 100);

        // Saturation of the error counter.
        force dut.err_count = 16'hFFFE;
        repeat (2) @(posedge clk);
        #1;
        release dut.err_count;
        exp_err_cnt = 16'hFFFE;
        #1;
        checkOutput("sat preload", 64'(err_count), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(vecs[2], 200 + k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
